fetch_control: RTL and testbench
================================

Name: fetch_control

Overview:
- Pipeline sequencing controller for the 5-stage RV32i core. Owns the fetch stage's PC_En and next-PC select, and issues stall/flush controls to the F/D and D/E pipeline registers.
- Resolves the following events by fixed priority: post-reset boot bubbles, taken branch/jump redirect from Execute, load-use stall, and EBREAK halt/resume.
- Sits beside the fetch stage; its outputs go directly to the fetch PC, the PC mux and the pipeline registers.

Parameters:
RESET_BUBBLES, 1, cycles after reset release with fetch held and both pipeline registers flushed (0 = none)
STALL_CNT_W, 32, width of the optional stall counter

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
Rs1_D  in  5  source reg 1 of instruction in Decode
Rs2_D  in  5  source reg 2 of instruction in Decode
Rd_E  in  5  destination reg of instruction in Execute
Mem_Read_E  in  1  instruction in Execute is a load
PC_Src_E  in  1  taken branch/jump resolved in Execute
Halt_Req_D  in  1  EBREAK decoded in Decode
Resume  in  1  single-cycle resume pulse from debug/testbench
PC_En  out  1  fetch PC write enable
PC_Sel  out  1  0 = PC+4, 1 = branch target from Execute
Stall_D  out  1  hold F/D register
Flush_D  out  1  clear F/D register to NOP
Flush_E  out  1  clear D/E register to NOP
Halted  out  1  registered, high while in HALT

Behaviour:
- One clock; reset is synchronous and active-high (CLK, RST).
- States: BOOT, RUN, HALT. There is a 2-bit-wide-or-larger bubble counter.
- RST high at an edge sets state to BOOT (or RUN if RESET_BUBBLES=0), sets the counter to RESET_BUBBLES, sets Halted=0. This applies mid-halt and mid-stall.
- Outputs while RST is high, and in BOOT: PC_En=0, PC_Sel=0, Stall_D=0, Flush_D=1, Flush_E=1.
- BOOT: counter decrements each cycle. When the counter is 1, move to RUN at the next edge.
- RUN outputs are combinational from state and inputs, evaluated in priority order:
  1. Redirect: PC_Src_E=1 gives PC_En=1, PC_Sel=1, Flush_D=1, Flush_E=1, Stall_D=0. Redirect overrides load-use and halt in the same cycle (the Decode instruction is wrong-path).
  2. Load-use: Mem_Read_E && Rd_E!=0 && (Rd_E==Rs1_D || Rd_E==Rs2_D) gives PC_En=0, Stall_D=1, Flush_E=1. Lasts exactly one cycle (bubble enters E). No state change.
  3. Halt: Halt_Req_D=1 gives PC_En=0, Stall_D=1, Flush_E=1. State moves to HALT next cycle; Halted=1 from the next cycle. If load-use and Halt_Req_D coincide, load-use wins and the halt is taken next cycle.
  4. Default: PC_En=1, PC_Sel=0, all others 0.
- HALT:
  - Resume=0: PC_En=0, Stall_D=1, Flush_E=1, Flush_D=0. PC_Src_E is ignored (E holds bubbles).
  - Resume=1: PC_En=1, PC_Sel=0, Flush_D=1 (discard EBREAK), Stall_D=0, Flush_E=1. Move to RUN; Halted=0 next cycle.
- Resume outside HALT is ignored. Halt_Req_D in BOOT is ignored.
- Stall_D and Flush_D are never both 1.

Optional Feature:
- Macro FETCH_CTRL_STALL_CNT_EN.
- When defined:
  - Adds output Stall_Count [STALL_CNT_W-1:0].
  - Increments by 1 on every RUN cycle with a load-use stall, and every HALT cycle.
  - Wraps at the maximum value to 0. Cleared by RST.
- When undefined: the port and counter are absent. Core behaviour is identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - enum fc_state_t {BOOT, RUN, HALT}
  - constants PC_SEL_PLUS4=1'b0, PC_SEL_TARGET=1'b1, REG_ZERO=5'd0
- One combinational sub-module, hazard_detect, produces the load-use signal. It is reused later by the forwarding unit.

Test Plan:
- Reset: RST=1 for 2 cycles, RESET_BUBBLES=1.
  - During RST and 1 cycle after: PC_En=0, Flush_D=1, Flush_E=1.
  - From cycle 2 after release: PC_En=1, Halted=0.
- Load-use: Mem_Read_E=1, Rd_E=5, Rs2_D=5 for one cycle.
  - That cycle: PC_En=0, Stall_D=1, Flush_E=1.
  - Next cycle (Mem_Read_E=0): PC_En=1.
- x0 case: Mem_Read_E=1, Rd_E=0, Rs1_D=0 gives no stall (PC_En=1).
- Redirect priority: PC_Src_E=1 with load-use and Halt_Req_D=1 in the same cycle.
  - PC_En=1, PC_Sel=1, Flush_D=1, Flush_E=1, Stall_D=0.
  - State remains RUN.
- Halt/resume: Halt_Req_D=1.
  - Halted=1 next cycle. PC_En stays 0 for 10 cycles.
  - Pulse Resume: that cycle PC_En=1, Flush_D=1. Halted=0 next cycle.
- Reset mid-halt: in HALT assert RST.
  - Next cycle: state BOOT, Halted=0.
  - With FETCH_CTRL_STALL_CNT_EN: Stall_Count=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32i pipeline control path.
package pipeline_pkg;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fc_state_t;

   localparam logic       PC_SEL_PLUS4  = 1'b0;
   localparam logic       PC_SEL_TARGET = 1'b1;
   localparam logic [4:0] REG_ZERO      = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between Decode sources and an Execute load.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic [4:0] rd_i,
   input  logic       mem_read_i,
   output logic       load_use_o
);

   assign load_use_o = mem_read_i
                     && (rd_i != REG_ZERO)
                     && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/fetch_control.sv
// Fetch/pipeline sequencing: boot bubbles, redirect, load-use, EBREAK halt.
// Optional stall counter output enabled by FETCH_CTRL_STALL_CNT_EN.
module fetch_control
   import pipeline_pkg::*;
#(
   parameter int unsigned RESET_BUBBLES = 1,
   parameter int unsigned STALL_CNT_W   = 32
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [4:0] Rs1_D,
   input  logic [4:0] Rs2_D,
   input  logic [4:0] Rd_E,
   input  logic       Mem_Read_E,
   input  logic       PC_Src_E,
   input  logic       Halt_Req_D,
   input  logic       Resume,
   output logic       PC_En,
   output logic       PC_Sel,
   output logic       Stall_D,
   output logic       Flush_D,
   output logic       Flush_E,
   output logic       Halted
`ifdef FETCH_CTRL_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] Stall_Count
`endif
);

   localparam int CNT_W =
      (RESET_BUBBLES < 4) ? 2 : $clog2(RESET_BUBBLES + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_BUBBLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam fc_state_t RST_STATE =
      (RESET_BUBBLES == 0) ? RUN : BOOT;

   fc_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halted_q;
   logic             load_use;

   hazard_detect u_hazard (
      .rs1_i      (Rs1_D),
      .rs2_i      (Rs2_D),
      .rd_i       (Rd_E),
      .mem_read_i (Mem_Read_E),
      .load_use_o (load_use)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      PC_En   = 1'b0;
      PC_Sel  = PC_SEL_PLUS4;
      Stall_D = 1'b0;
      Flush_D = 1'b0;
      Flush_E = 1'b0;
      if (RST) begin
         Flush_D = 1'b1;
         Flush_E = 1'b1;
      end else begin
         unique case (state_q)
            BOOT: begin
               Flush_D = 1'b1;
               Flush_E = 1'b1;
               cnt_d   = cnt_q - CNT_ONE;
               if (cnt_q <= CNT_ONE) state_d = RUN;
            end
            RUN: begin
               // Redirect wins: the Decode instruction is wrong-path.
               if (PC_Src_E) begin
                  PC_En   = 1'b1;
                  PC_Sel  = PC_SEL_TARGET;
                  Flush_D = 1'b1;
                  Flush_E = 1'b1;
               end else if (load_use) begin
                  Stall_D = 1'b1;
                  Flush_E = 1'b1;
               end else if (Halt_Req_D) begin
                  Stall_D = 1'b1;
                  Flush_E = 1'b1;
                  state_d = HALT;
               end else begin
                  PC_En = 1'b1;
               end
            end
            HALT: begin
               Flush_E = 1'b1;
               if (Resume) begin
                  PC_En   = 1'b1;
                  Flush_D = 1'b1;
                  state_d = RUN;
               end else begin
                  Stall_D = 1'b1;
               end
            end
            default: state_d = RST_STATE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= RST_STATE;
         cnt_q    <= CNT_INIT;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         halted_q <= (state_d == HALT);
      end
   end

   assign Halted = halted_q;

`ifdef FETCH_CTRL_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic                   stall_evt;

   assign stall_evt = !RST
      && (((state_q == RUN) && !PC_Src_E && load_use)
          || (state_q == HALT));

   always_ff @(posedge CLK) begin
      if (RST) stall_cnt_q <= '0;
      else if (stall_evt) stall_cnt_q <= stall_cnt_q + 1'b1;
   end

   assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_control.sv
// Directed plus randomized bench for fetch_control with a behavioural model.
module tb_fetch_control;

   localparam int RB = 1;
   localparam int SW = 32;

   logic       CLK = 1'b0;
   logic       RST;
   logic [4:0] Rs1_D, Rs2_D, Rd_E;
   logic       Mem_Read_E, PC_Src_E, Halt_Req_D, Resume;
   logic       PC_En, PC_Sel, Stall_D, Flush_D, Flush_E, Halted;
`ifdef FETCH_CTRL_STALL_CNT_EN
   logic [SW-1:0] Stall_Count;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 0;

   // Model: mode 0 = booting, 1 = running, 2 = halted.
   int            mode = 0;
   int            boot_left = 0;
   bit            m_halted = 0;
   logic [SW-1:0] m_sc = '0;

   fetch_control #(
      .RESET_BUBBLES (RB),
      .STALL_CNT_W   (SW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .Rs1_D      (Rs1_D),
      .Rs2_D      (Rs2_D),
      .Rd_E       (Rd_E),
      .Mem_Read_E (Mem_Read_E),
      .PC_Src_E   (PC_Src_E),
      .Halt_Req_D (Halt_Req_D),
      .Resume     (Resume),
      .PC_En      (PC_En),
      .PC_Sel     (PC_Sel),
      .Stall_D    (Stall_D),
      .Flush_D    (Flush_D),
      .Flush_E    (Flush_E),
      .Halted     (Halted)
`ifdef FETCH_CTRL_STALL_CNT_EN
      ,
      .Stall_Count (Stall_Count)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic bit lu_now();
      return Mem_Read_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
   endfunction

   // {PC_En, PC_Sel, Stall_D, Flush_D, Flush_E}
   function automatic logic [4:0] exp_out();
      if (RST || mode == 0) return 5'b00011;
      if (mode == 2) return Resume ? 5'b10011 : 5'b00101;
      if (PC_Src_E) return 5'b11011;
      if (lu_now() || Halt_Req_D) return 5'b00101;
      return 5'b10000;
   endfunction

   always @(posedge CLK) begin
      if (RST) begin
         mode      = (RB == 0) ? 1 : 0;
         boot_left = RB;
         m_sc      = '0;
      end else if (mode == 0) begin
         boot_left = boot_left - 1;
         if (boot_left == 0) mode = 1;
      end else if (mode == 1) begin
         if (!PC_Src_E && lu_now()) m_sc = m_sc + 1'b1;
         else if (!PC_Src_E && Halt_Req_D) mode = 2;
      end else begin
         m_sc = m_sc + 1'b1;
         if (Resume) mode = 1;
      end
      m_halted = (mode == 2);
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         logic [4:0] got, exp;
         got = {PC_En, PC_Sel, Stall_D, Flush_D, Flush_E};
         exp = exp_out();
         n_checks++;
         if (got !== exp || Halted !== m_halted) begin
            n_errors++;
            $display("FAIL model t=%0t outs got=%b exp=%b halted got=%b exp=%b",
                     $time, got, exp, Halted, m_halted);
         end
`ifdef FETCH_CTRL_STALL_CNT_EN
         n_checks++;
         if (Stall_Count !== m_sc) begin
            n_errors++;
            $display("FAIL model_cnt t=%0t got=%0d exp=%0d",
                     $time, Stall_Count, m_sc);
         end
`endif
      end
   end

   task automatic lit(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic clr();
      Rs1_D = 0; Rs2_D = 0; Rd_E = 0;
      Mem_Read_E = 0; PC_Src_E = 0; Halt_Req_D = 0; Resume = 0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1;
      clr();
      tick();
      chk_en = 1;
      @(negedge CLK);
      lit("rst_pc_en", PC_En, 0);
      lit("rst_flush", {Flush_D, Flush_E}, 2'b11);
      tick();
      RST = 1'b0;
      @(negedge CLK);
      lit("boot_pc_en", PC_En, 0);
      lit("boot_flush", {Flush_D, Flush_E}, 2'b11);
      tick();
      @(negedge CLK);
      lit("run_pc_en", PC_En, 1);
      lit("run_halted", Halted, 0);

      tick();
      Mem_Read_E = 1; Rd_E = 5; Rs1_D = 1; Rs2_D = 5;
      @(negedge CLK);
      lit("lu_outs", {PC_En, Stall_D, Flush_E}, 3'b011);
      tick();
      Mem_Read_E = 0;
      @(negedge CLK);
      lit("lu_after", PC_En, 1);

      tick();
      Mem_Read_E = 1; Rd_E = 0; Rs1_D = 0; Rs2_D = 0;
      @(negedge CLK);
      lit("x0_no_stall", {PC_En, Stall_D}, 2'b10);

      tick();
      PC_Src_E = 1; Rd_E = 5; Rs1_D = 5; Halt_Req_D = 1;
      @(negedge CLK);
      lit("redir_outs", {PC_En, PC_Sel, Flush_D, Flush_E, Stall_D},
          5'b11110);
      tick();
      clr();
      @(negedge CLK);
      lit("redir_still_run", {PC_En, Halted}, 2'b10);

      tick();
      Halt_Req_D = 1;
      @(negedge CLK);
      lit("halt_req", {PC_En, Stall_D}, 2'b01);
      for (int i = 0; i < 10; i++) begin
         tick();
         Halt_Req_D = 0;
         @(negedge CLK);
         lit("halted_hold", {Halted, PC_En}, 2'b10);
      end
      tick();
      Resume = 1;
      @(negedge CLK);
      lit("resume_outs", {PC_En, Flush_D, Stall_D}, 3'b110);
      tick();
      Resume = 0;
      @(negedge CLK);
      lit("resumed", {Halted, PC_En}, 2'b01);
`ifdef FETCH_CTRL_STALL_CNT_EN
      lit("stall_cnt", Stall_Count, 12);
`endif

      tick();
      Halt_Req_D = 1;
      tick();
      Halt_Req_D = 0;
      @(negedge CLK);
      lit("pre_rst_halted", Halted, 1);
      tick();
      RST = 1;
      tick();
      RST = 0;
      @(negedge CLK);
      lit("midhalt_rst", {Halted, PC_En, Flush_D}, 3'b001);
`ifdef FETCH_CTRL_STALL_CNT_EN
      lit("midhalt_cnt", Stall_Count, 0);
`endif
      tick();
      @(negedge CLK);
      lit("midhalt_run", PC_En, 1);

      for (int i = 0; i < 3000; i++) begin
         tick();
         RST        = ($urandom_range(99) == 0);
         Rs1_D      = 5'($urandom_range(3));
         Rs2_D      = 5'($urandom_range(3));
         Rd_E       = 5'($urandom_range(3));
         Mem_Read_E = ($urandom_range(2) == 0);
         PC_Src_E   = ($urandom_range(5) == 0);
         Halt_Req_D = ($urandom_range(9) == 0);
         Resume     = ($urandom_range(7) == 0);
      end
      @(negedge CLK);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
